// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the frame sequencer.
// State codes are plain localparams so legacy tooling can read them.
package frame_seq_pkg;

    localparam int CNT_W = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [CNT_W-1:0] FIRST_FRAME = '0;

    function automatic logic [CNT_W-1:0] last_frame(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/frame_prescaler.sv
// Frame prescaler: counts 0..max(divisor,1)-1, pulses tc on terminal count.
// A divisor of zero behaves as one (terminal every enabled cycle).
module frame_prescaler
    import frame_seq_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] divisor,
    output logic             tc
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_eff;

    assign div_eff = (divisor == '0) ? DIV_W'(1) : divisor;
    // a count past a freshly lowered divisor also terminates
    assign tc = en && (cnt >= div_eff - DIV_W'(1));

    // count while enabled, wrap on terminal, clear on request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: paced 3-bit frame select with start/pause/abort FSM.
// Define FRAME_SEQ_PINGPONG_EN to enable bounce mode in loop runs.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int DIV_W      = 24,
    parameter int NUM_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             dir,
    input  logic             loop_en,
    input  logic             pingpong,
    input  logic [DIV_W-1:0] divisor,
    output logic [CNT_W-1:0] Contador,
    output logic             step_tick,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = last_frame(NUM_FRAMES);

    logic [1:0]       state;
    logic             dir_q;
    logic             loop_q;
    logic             tc;
    logic             en;
    logic             clr;
    logic             at_end;
    logic             bounce;
    logic [CNT_W-1:0] nxt;
    logic             nxt_dir;

    assign busy   = (state == RUN) || (state == HOLD);
    assign en     = busy && !pause && !abort && !start;
    assign clr    = start || abort;
    assign at_end = dir_q ? (Contador == FIRST_FRAME)
                          : (Contador == LAST);

`ifdef FRAME_SEQ_PINGPONG_EN
    logic pp_q;

    assign bounce = pp_q && loop_q && at_end && (NUM_FRAMES > 1);

    // bounce selection is captured once per run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_q <= 1'b0;
        end else if (start && !abort) begin
            pp_q <= pingpong;
        end
    end
`else
    logic unused_pp;

    assign bounce    = 1'b0;
    assign unused_pp = pingpong;
`endif

    frame_prescaler #(
        .DIV_W(DIV_W)
    ) u_pre (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (clr),
        .divisor(divisor),
        .tc     (tc)
    );

    // next frame: bounce reverses, otherwise step or wrap
    always_comb begin
        nxt     = Contador;
        nxt_dir = dir_q;
        if (bounce) begin
            nxt_dir = !dir_q;
            nxt     = dir_q ? Contador + 3'd1 : Contador - 3'd1;
        end else if (at_end) begin
            nxt = dir_q ? LAST : FIRST_FRAME;
        end else begin
            nxt = dir_q ? Contador - 3'd1 : Contador + 3'd1;
        end
    end

    // FSM, frame register and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            Contador  <= '0;
            step_tick <= 1'b0;
            done      <= 1'b0;
            dir_q     <= 1'b0;
            loop_q    <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else if (start) begin
                state    <= RUN;
                Contador <= dir ? LAST : FIRST_FRAME;
                dir_q    <= dir;
                loop_q   <= loop_en;
            end else if (busy) begin
                state <= pause ? HOLD : RUN;
                if (tc) begin
                    if (at_end && !loop_q) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        Contador  <= nxt;
                        dir_q     <= nxt_dir;
                        step_tick <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed self-checking bench for frame_sequencer.
// Loop-mode sequence expectations follow FRAME_SEQ_PINGPONG_EN.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pause = 1'b0;
    logic        dir = 1'b0;
    logic        loop_en = 1'b0;
    logic        pingpong = 1'b0;
    logic [23:0] divisor = 24'd1;
    logic [2:0]  Contador;
    logic        step_tick;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    frame_sequencer #(
        .DIV_W(24),
        .NUM_FRAMES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pause    (pause),
        .dir      (dir),
        .loop_en  (loop_en),
        .pingpong (pingpong),
        .divisor  (divisor),
        .Contador (Contador),
        .step_tick(step_tick),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic all_out(input string tag, input int c, input int s,
                           input int b, input int d);
        chk({tag, ".cnt"}, int'(Contador), c);
        chk({tag, ".step"}, int'(step_tick), s);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".done"}, int'(done), d);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int e;
        int p;
        // reset state
        tick(2);
        all_out("rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // up, loop, divisor 4
        divisor = 24'd4;
        dir = 1'b0;
        loop_en = 1'b1;
        do_start();
        all_out("up0", 0, 0, 1, 0);
        for (int k = 1; k <= 36; k++) begin
            tick();
            chk($sformatf("up.cnt%0d", k), int'(Contador), (k / 4) % 8);
            chk($sformatf("up.step%0d", k), int'(step_tick),
                (k % 4 == 0) ? 1 : 0);
        end

        // async reset mid-run, while step_tick is high
        rst = 1'b1;
        #2;
        all_out("arst", 0, 0, 0, 0);
        rst = 1'b0;
        tick(3);
        all_out("post_rst", 0, 0, 0, 0);

        // down, one-shot, divisor 2
        divisor = 24'd2;
        dir = 1'b1;
        loop_en = 1'b0;
        do_start();
        all_out("dn0", 7, 0, 1, 0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("dn.cnt%0d", k), int'(Contador), 7 - k / 2);
            chk($sformatf("dn.step%0d", k), int'(step_tick),
                (k % 2 == 0) ? 1 : 0);
            chk($sformatf("dn.busy%0d", k), int'(busy), 1);
        end
        tick();
        all_out("dn_done", 0, 0, 0, 1);
        tick();
        all_out("dn_after", 0, 0, 0, 0);

        // pause for 3 clocks mid-period
        divisor = 24'd5;
        dir = 1'b0;
        loop_en = 1'b1;
        do_start();
        tick(2);
        pause = 1'b1;
        tick();
        all_out("hold", 0, 0, 1, 0);
        tick(2);
        pause = 1'b0;
        tick(2);
        all_out("pz7", 0, 0, 1, 0);
        tick();
        all_out("pz8", 1, 1, 1, 0);

        // abort and start together: abort wins
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        all_out("abst", 1, 0, 0, 0);
        tick(6);
        all_out("abst_idle", 1, 0, 0, 0);

        // divisor 0, restart in RUN clears prescaler
        divisor = 24'd0;
        do_start();
        all_out("d0", 0, 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("d0.cnt%0d", k), int'(Contador), k);
            chk($sformatf("d0.step%0d", k), int'(step_tick), 1);
        end
        divisor = 24'd3;
        tick();
        all_out("d3_mid", 5, 0, 1, 0);
        do_start();
        all_out("rest0", 0, 0, 1, 0);
        tick(2);
        all_out("rest2", 0, 0, 1, 0);
        tick();
        all_out("rest3", 1, 1, 1, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        all_out("abort", 1, 0, 0, 0);

        // loop with pingpong requested, divisor 1
        divisor = 24'd1;
        dir = 1'b0;
        loop_en = 1'b1;
        pingpong = 1'b1;
        do_start();
        all_out("pp0", 0, 0, 1, 0);
        for (int k = 1; k <= 15; k++) begin
            tick();
`ifdef FRAME_SEQ_PINGPONG_EN
            p = k % 14;
            e = (p <= 7) ? p : 14 - p;
`else
            p = k;
            e = p % 8;
`endif
            chk($sformatf("pp.cnt%0d", k), int'(Contador), e);
            chk($sformatf("pp.step%0d", k), int'(step_tick), 1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("pp_abort.busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
